reg_file: RTL

CPU register file and flag/interrupt-enable state for the GameBoy core, sitting directly around the `alu`. Supplies `op_A`/`op_B` and `curr_flags` to the ALU and consumes its outputs (`alu_result`, `next_flags`, `addr_result`, `PC_inc_h`/`PC_dec_h`) as write-back. Holds A, F, B, C, D, E, H, L, SP and PC, plus IME with the EI one-instruction delay.

---
 rtl/reg_file.sv | 131 +++++++++++++
 1 files changed

// File: rtl/reg_file.sv
// reg_file: GameBoy CPU register file with flags, SP/PC and the IME enable state around the ALU
// Ports: clk, rst (async active-high); rd_sel_A/rd_sel_B -> op_A/op_B byte reads;
//   wr_en/wr_sel/wr_data byte write; pair_wr_en/pair_sel/pair_data 16-bit pair write;
//   flag_ld/next_flags -> curr_flags; pc_ld/pc_data, pc_inc, pc_rel_ld/PC_inc_h/PC_dec_h PC updates;
//   ei/di/reti/instr_done -> ime; pc/sp/hl direct pair outputs.
//   Define BOOT_SKIP_EN to reset into the post-boot-ROM register state.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rd_sel_A,
  input  logic [3:0]  rd_sel_B,
  output logic [7:0]  op_A,
  output logic [7:0]  op_B,
  input  logic        wr_en,
  input  logic [3:0]  wr_sel,
  input  logic [7:0]  wr_data,
  input  logic        pair_wr_en,
  input  logic [1:0]  pair_sel,
  input  logic [15:0] pair_data,
  input  logic        flag_ld,
  input  logic [3:0]  next_flags,
  output logic [3:0]  curr_flags,
  input  logic        pc_ld,
  input  logic [15:0] pc_data,
  input  logic        pc_inc,
  input  logic        pc_rel_ld,
  input  logic        PC_inc_h,
  input  logic        PC_dec_h,
  input  logic        ei,
  input  logic        di,
  input  logic        reti,
  input  logic        instr_done,
  output logic        ime,
  output logic [15:0] pc,
  output logic [15:0] sp,
  output logic [15:0] hl
);
`ifdef BOOT_SKIP_EN
  localparam logic [7:0]  RA = 8'h01, RB = 8'h00, RC = 8'h13, RD = 8'h00, RE = 8'hD8, RH = 8'h01, RL = 8'h4D;
  localparam logic [3:0]  RF = 4'hB;
  localparam logic [15:0] RSP = 16'hFFFE, RPC = 16'h0100;
`else
  localparam logic [7:0]  RA = 8'h00, RB = 8'h00, RC = 8'h00, RD = 8'h00, RE = 8'h00, RH = 8'h00, RL = 8'h00;
  localparam logic [3:0]  RF = 4'h0;
  localparam logic [15:0] RSP = 16'h0000, RPC = 16'h0000;
`endif
  typedef enum logic [1:0] {IDLE, ARMED, DELAY} ime_t;
  ime_t st;
  logic [7:0] a, b, c, d, e, h, l;
  logic [3:0] fl;
  logic [11:0] w;
  logic [3:0] p;
  logic [7:0] pch;
  // Only the flag nibble is stored; F[3:0] is hard-wired to zero.
  function automatic logic [7:0] rd(input logic [3:0] s);
    case (s)
      4'd0:    rd = b;
      4'd1:    rd = c;
      4'd2:    rd = d;
      4'd3:    rd = e;
      4'd4:    rd = h;
      4'd5:    rd = l;
      4'd6:    rd = {fl, 4'h0};
      4'd7:    rd = a;
      4'd8:    rd = sp[15:8];
      4'd9:    rd = sp[7:0];
      4'd10:   rd = pc[15:8];
      4'd11:   rd = pc[7:0];
      default: rd = 8'h00;
    endcase
  endfunction
  assign op_A = rd(rd_sel_A);
  assign op_B = rd(rd_sel_B);
  assign curr_flags = fl;
  assign hl = {h, l};
  always_comb begin
    for (int i = 0; i < 12; i++) w[i] = wr_en && wr_sel == 4'(i);
    p = pair_wr_en ? 4'b0001 << pair_sel : 4'b0000;
    // Conflicting carry/borrow requests cancel out.
    pch = (PC_inc_h && !PC_dec_h) ? pc[15:8] + 8'd1 : (PC_dec_h && !PC_inc_h) ? pc[15:8] - 8'd1 : pc[15:8];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a <= RA;
      fl <= RF;
      b <= RB;
      c <= RC;
      d <= RD;
      e <= RE;
      h <= RH;
      l <= RL;
      sp <= RSP;
      pc <= RPC;
    end else begin
      b <= w[0] ? wr_data : p[0] ? pair_data[15:8] : b;
      c <= w[1] ? wr_data : p[0] ? pair_data[7:0] : c;
      d <= w[2] ? wr_data : p[1] ? pair_data[15:8] : d;
      e <= w[3] ? wr_data : p[1] ? pair_data[7:0] : e;
      h <= w[4] ? wr_data : p[2] ? pair_data[15:8] : h;
      l <= w[5] ? wr_data : p[2] ? pair_data[7:0] : l;
      fl <= w[6] ? wr_data[7:4] : flag_ld ? next_flags : fl;
      a <= w[7] ? wr_data : a;
      sp <= {w[8] ? wr_data : p[3] ? pair_data[15:8] : sp[15:8],
             w[9] ? wr_data : p[3] ? pair_data[7:0] : sp[7:0]};
      // One PC source wins outright; lower-priority sources never merge in.
      pc <= pc_ld ? pc_data :
            pc_rel_ld ? {pch, wr_data} :
            |w[11:10] ? {w[10] ? wr_data : pc[15:8], w[11] ? wr_data : pc[7:0]} :
            pc_inc ? pc + 16'd1 : pc;
    end
  // EI takes effect after the instruction following it: ARMED waits for EI's own
  // completion, DELAY waits for the next instruction's completion.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      ime <= 1'b0;
    end else if (di) begin
      st <= IDLE;
      ime <= 1'b0;
    end else if (reti) begin
      st <= IDLE;
      ime <= 1'b1;
    end else if (ei)
      st <= ARMED;
    else if (instr_done && st == ARMED)
      st <= DELAY;
    else if (instr_done && st == DELAY) begin
      st <= IDLE;
      ime <= 1'b1;
    end
endmodule
